systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
Sequencer for an ARRAY_SIZE x ARRAY_SIZE grid of pe instances performing one tile matmul per start. Issues operand-buffer reads and a per-lane skew-valid mask, and clears the array before each tile. After the array pipeline drains, it walks the result rows out to the output buffer. Sits between the top-level TPU FSM and the array/SRAM wrappers; does not touch data, only control and addresses.

Parameters:
ARRAY_SIZE, 4, rows/columns of the PE grid; lanes in skew mask
ADDR_W, 16, SRAM address width for A, B and output buffers
K_W, 8, width of the accumulation-length field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only in IDLE
k_len  in  K_W  accumulation depth K; sampled with start
a_base  in  ADDR_W  A-buffer base address; sampled with start
b_base  in  ADDR_W  B-buffer base address; sampled with start
out_base  in  ADDR_W  output-buffer base address; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE state
array_clr  out  1  clear to all PEs (drives pe rst)
rd_en  out  1  A/B buffer read enable
a_addr  out  ADDR_W  A read address
b_addr  out  ADDR_W  B read address
lane_valid  out  ARRAY_SIZE  bit i = lane i operand valid this cycle
wr_en  out  1  output-buffer write enable
wr_addr  out  ADDR_W  output write address
row_sel  out  clog2(ARRAY_SIZE)  array result row muxed to output
perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset: state IDLE; all outputs 0; latched bases/K and counters 0. rst wins over start. rst mid-operation aborts in one edge, with no further rd_en/wr_en.
- All outputs are registered; state and counter update on posedge clk only.
- IDLE: start=1 and k_len!=0 -> latch k_len and bases, go to CLEAR. start with k_len==0 -> go directly to DONE (no reads, no writes, no clear). start in any other state is ignored.
- CLEAR: 1 cycle, array_clr=1, then FEED with cnt=0.
- FEED: K+ARRAY_SIZE cycles, cnt=0..K+ARRAY_SIZE-1.
  - rd_en=1 iff cnt<K.
  - a_addr=a_base+cnt and b_addr=b_base+cnt, modulo 2^ADDR_W (wrap, no error).
  - Addresses hold their last value when rd_en=0.
  - lane_valid[i]=1 iff i+1 <= cnt <= i+K. This accounts for the 1-cycle SRAM read latency and a skew of i cycles on lane i.
- DRAIN: ARRAY_SIZE+1 cycles, all strobes 0 (PE pipeline flush).
- WRITE: ARRAY_SIZE cycles, row r=0..N-1.
  - wr_en=1, row_sel=r, wr_addr=out_base+r (modulo wrap).
- DONE: 1 cycle, done=1, busy=1, then IDLE. start arriving in DONE is ignored.
- Latency for K>0: CLEAR starts the cycle after start. done is asserted 1+(K+N)+(N+1)+N cycles after that (N=ARRAY_SIZE).
- Strobe exclusivity: array_clr, rd_en and wr_en are never high in the same cycle.

Optional Feature:
SYSTOLIC_CTRL_PERF_EN
- Defined: a 32-bit counter clears on start acceptance and increments in every non-IDLE cycle, DONE included. It saturates at 0xFFFFFFFF. perf_cycles holds the count of the last completed op until the next accepted start; it is 0 after reset.
- Undefined: perf_cycles is tied to 0 and no counter logic exists.

Decomposition:
- Shared define/package: DATA_SIZE (existing), state encoding localparams (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE), and the ADDR_W default.
- One sub-module: systolic_skew_gen. It is combinational-plus-register: inputs cnt and K, output lane_valid. Reused by the weight-loader later.

Test Plan:
- Reset, then N=4, K=3, bases A=0x10, B=0x20, out=0x40, start pulse at cycle 0:
  - array_clr at cycle 1.
  - rd_en at cycles 2-4, with a_addr 0x10-0x12 and b_addr 0x20-0x22.
  - lane_valid 0001,0011,0111,1110,1100,1000 at cycles 3-8.
  - wr_en at cycles 14-17, wr_addr 0x40-0x43, row_sel 0-3.
  - done at cycle 18 only; busy at cycles 1-18.
- start with k_len=0 -> done the next cycle, busy high 1 cycle, no rd_en/wr_en/array_clr.
- start pulsed again during FEED and during DONE -> ignored; exactly one done; a new start accepted only after IDLE.
- a_base=0xFFFE, K=4 -> a_addr FFFE, FFFF, 0000, 0001.
- rst asserted during WRITE row 2 -> the next cycle shows all outputs 0 and state IDLE; a following start runs a full, correct sequence.
- With SYSTOLIC_CTRL_PERF_EN defined, the K=3/N=4 case -> perf_cycles=18 after done and stays stable until the next start.

Source files
------------

// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and defaults for the systolic array sequencer and its helpers.
package systolic_array_ctrl_pkg;

   localparam int unsigned DATA_SIZE  = 8;
   localparam int unsigned ADDR_W_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } ctrl_state_t;

endpackage

// File: rtl/systolic_array_ctrl_skew_gen.sv
// Per-lane operand-valid mask: lane i is valid for cnt in [i+1, i+K], registered.
import systolic_array_ctrl_pkg::*;

module systolic_skew_gen #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned CNT_W      = 9,
   parameter int unsigned K_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [CNT_W-1:0]      cnt,
   input  logic [K_W-1:0]        k,
   output logic [ARRAY_SIZE-1:0] lane_valid
);

   logic [ARRAY_SIZE-1:0] lane_nxt;

   // Lower bound i+1 covers the one-cycle SRAM read latency plus the lane skew.
   always_comb begin
      lane_nxt = '0;
      for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
         if (en && (32'(cnt) >= i + 1) && (32'(cnt) <= i + 32'(k)))
            lane_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lane_valid <= '0;
      else     lane_valid <= lane_nxt;
   end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile-matmul sequencer: CLEAR, FEED, DRAIN, WRITE, DONE; all outputs registered.
// Optional cycle counter on perf_cycles enabled by SYSTOLIC_CTRL_PERF_EN.
import systolic_array_ctrl_pkg::*;

module systolic_array_ctrl #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned K_W        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [K_W-1:0]                k_len,
   input  logic [ADDR_W-1:0]             a_base,
   input  logic [ADDR_W-1:0]             b_base,
   input  logic [ADDR_W-1:0]             out_base,
   output logic                          busy,
   output logic                          done,
   output logic                          array_clr,
   output logic                          rd_en,
   output logic [ADDR_W-1:0]             a_addr,
   output logic [ADDR_W-1:0]             b_addr,
   output logic [ARRAY_SIZE-1:0]         lane_valid,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [$clog2(ARRAY_SIZE)-1:0] row_sel,
   output logic [31:0]                   perf_cycles
);

   localparam int unsigned     CNT_W = K_W + 1;
   localparam int unsigned     RS_W  = $clog2(ARRAY_SIZE);
   localparam logic [CNT_W-1:0] N_C   = CNT_W'(ARRAY_SIZE);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   ctrl_state_t       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [K_W-1:0]    k_q;
   logic [ADDR_W-1:0] a_base_q, b_base_q, out_base_q;
   logic [CNT_W-1:0]  k_ext;
   logic              accept, feed_nxt, rd_nxt, wr_nxt;

   assign k_ext    = {1'b0, k_q};
   assign accept   = (state == S_IDLE) && start;
   assign feed_nxt = (state_nxt == S_FEED);
   assign rd_nxt   = feed_nxt && (cnt_nxt < k_ext);
   assign wr_nxt   = (state_nxt == S_WRITE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_nxt   = '0;
               state_nxt = (k_len != '0) ? S_CLEAR : S_DONE;
            end
         end
         S_CLEAR: begin
            state_nxt = S_FEED;
            cnt_nxt   = '0;
         end
         S_FEED: begin
            if (cnt == k_ext + N_C - ONE_C) begin
               state_nxt = S_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ONE_C;
            end
         end
         S_DRAIN: begin
            if (cnt == N_C) begin
               state_nxt = S_WRITE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ONE_C;
            end
         end
         S_WRITE: begin
            if (cnt == N_C - ONE_C) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ONE_C;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         k_q        <= '0;
         a_base_q   <= '0;
         b_base_q   <= '0;
         out_base_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         array_clr  <= 1'b0;
         rd_en      <= 1'b0;
         a_addr     <= '0;
         b_addr     <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         row_sel    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         if (accept && (k_len != '0)) begin
            k_q        <= k_len;
            a_base_q   <= a_base;
            b_base_q   <= b_base;
            out_base_q <= out_base;
         end
         busy      <= (state_nxt != S_IDLE);
         done      <= (state_nxt == S_DONE);
         array_clr <= (state_nxt == S_CLEAR);
         rd_en     <= rd_nxt;
         if (rd_nxt) begin
            a_addr <= a_base_q + ADDR_W'(cnt_nxt);
            b_addr <= b_base_q + ADDR_W'(cnt_nxt);
         end
         wr_en     <= wr_nxt;
         if (wr_nxt) begin
            wr_addr <= out_base_q + ADDR_W'(cnt_nxt);
            row_sel <= RS_W'(cnt_nxt);
         end
      end
   end

   systolic_skew_gen #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .CNT_W      (CNT_W),
      .K_W        (K_W)
   ) u_skew (
      .clk        (clk),
      .rst        (rst),
      .en         (feed_nxt),
      .cnt        (cnt_nxt),
      .k          (k_q),
      .lane_valid (lane_valid)
   );

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst)
         perf_q <= '0;
      else if (accept)
         perf_q <= '0;
      else if ((state != S_IDLE) && (perf_q != '1))
         perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: offset-based reference model plus literal spot checks.
module tb_systolic_array_ctrl;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  k_len;
   logic [15:0] a_base, b_base, out_base;
   logic        busy, done, array_clr, rd_en, wr_en;
   logic [15:0] a_addr, b_addr, wr_addr;
   logic [3:0]  lane_valid;
   logic [1:0]  row_sel;
   logic [31:0] perf_cycles;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   systolic_array_ctrl #(.ARRAY_SIZE(4), .ADDR_W(16), .K_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .a_base(a_base), .b_base(b_base), .out_base(out_base),
      .busy(busy), .done(done), .array_clr(array_clr), .rd_en(rd_en),
      .a_addr(a_addr), .b_addr(b_addr), .lane_valid(lane_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .row_sel(row_sel),
      .perf_cycles(perf_cycles)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an operation is an offset d from the accepting edge; every
   // output follows from d, K and the phase lengths 1, K+N, N+1, N, 1.
   logic        m_valid = 1'b0;
   logic        m_active, m_wclean;
   int          m_d, m_k;
   logic [31:0] m_ab, m_bb, m_ob, m_perf;
   logic [31:0] e_busy, e_done, e_clr, e_rd, e_wr, e_lv;
   logic [31:0] e_a, e_b, e_wa, e_rs;

   function automatic int done_off(input int k);
      return (k == 0) ? 1 : k + 3 * N + 3;
   endfunction

   always @(posedge clk) begin
      int f, r;
      if (rst) begin
         m_valid = 1'b1; m_active = 1'b0; m_wclean = 1'b1;
         m_perf = 0; e_a = 0; e_b = 0; e_wa = 0; e_rs = 0;
      end else if (m_valid) begin
         if (m_active) begin
            if (m_perf != 32'hFFFF_FFFF) m_perf++;
            if (m_d == done_off(m_k)) m_active = 1'b0;
            else m_d++;
         end else if (start) begin
            m_active = 1'b1; m_d = 1; m_k = int'(k_len); m_perf = 0;
            if (k_len != 0) begin
               m_ab = 32'(a_base); m_bb = 32'(b_base); m_ob = 32'(out_base);
            end
         end
      end
      e_busy = 0; e_done = 0; e_clr = 0; e_rd = 0; e_wr = 0; e_lv = 0;
      if (!rst && m_active) begin
         e_busy = 1;
         e_done = 32'(m_d == done_off(m_k));
         if (m_k > 0) begin
            e_clr = 32'(m_d == 1);
            f = m_d - 2;
            if (m_d >= 2 && m_d <= m_k + N + 1) begin
               if (f < m_k) begin
                  e_rd = 1;
                  e_a = (m_ab + 32'(f)) & 32'hFFFF;
                  e_b = (m_bb + 32'(f)) & 32'hFFFF;
               end
               for (int i = 0; i < N; i++)
                  if (f >= i + 1 && f <= i + m_k) e_lv = e_lv | (32'd1 << i);
            end
            r = m_d - (m_k + 2 * N + 3);
            if (r >= 0 && r < N) begin
               e_wr = 1; m_wclean = 1'b0;
               e_wa = (m_ob + 32'(r)) & 32'hFFFF;
               e_rs = 32'(r);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_busy", 32'(busy), e_busy);
         chk("m_done", 32'(done), e_done);
         chk("m_clr", 32'(array_clr), e_clr);
         chk("m_rd_en", 32'(rd_en), e_rd);
         chk("m_wr_en", 32'(wr_en), e_wr);
         chk("m_lane_valid", 32'(lane_valid), e_lv);
         chk("m_a_addr", 32'(a_addr), e_a);
         chk("m_b_addr", 32'(b_addr), e_b);
         if (e_wr != 0 || m_wclean) begin
            chk("m_wr_addr", 32'(wr_addr), e_wa);
            chk("m_row_sel", 32'(row_sel), e_rs);
         end
`ifdef SYSTOLIC_CTRL_PERF_EN
         chk("m_perf", perf_cycles, m_perf);
`else
         chk("m_perf", perf_cycles, 32'd0);
`endif
      end
   end

   task automatic launch(input int k, input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
      k_len = 8'(k); a_base = a; b_base = b; out_base = o; start = 1'b1;
   endtask

   logic [3:0] lv_tab [6];
   int         ndone;
   logic [31:0] perf_exp;

   initial begin
      lv_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
`ifdef SYSTOLIC_CTRL_PERF_EN
      perf_exp = 32'd18;
`else
      perf_exp = 32'd0;
`endif
      rst = 1'b1; start = 1'b0; k_len = '0; a_base = '0; b_base = '0; out_base = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_outputs", {16'(a_addr | b_addr | wr_addr), 8'(lane_valid), 2'(row_sel),
          done, array_clr, rd_en, wr_en, 2'b00}, 0);
      chk("rst_perf", perf_cycles, 0);
      rst = 1'b0;
      @(negedge clk);

      // K=3, N=4 reference sequence
      launch(3, 16'h0010, 16'h0020, 16'h0040);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) chk("t1_clr", 32'(array_clr), 1);
         chk("t1_rd_en", 32'(rd_en), 32'(c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) begin
            chk("t1_a_addr", 32'(a_addr), 32'h10 + 32'(c - 2));
            chk("t1_b_addr", 32'(b_addr), 32'h20 + 32'(c - 2));
         end
         if (c >= 3 && c <= 8) chk("t1_lane", 32'(lane_valid), 32'(lv_tab[c - 3]));
         chk("t1_wr_en", 32'(wr_en), 32'(c >= 14 && c <= 17));
         if (c >= 14 && c <= 17) begin
            chk("t1_wr_addr", 32'(wr_addr), 32'h40 + 32'(c - 14));
            chk("t1_row_sel", 32'(row_sel), 32'(c - 14));
         end
         chk("t1_done", 32'(done), 32'(c == 18));
         chk("t1_busy", 32'(busy), 32'(c <= 18));
         if (c >= 19) chk("t1_perf", perf_cycles, perf_exp);
      end

      // K=0: immediate done, no strobes
      launch(0, 16'h1111, 16'h2222, 16'h3333);
      @(negedge clk);
      start = 1'b0;
      chk("k0_done", 32'(done), 1);
      chk("k0_busy", 32'(busy), 1);
      chk("k0_strobes", 32'({array_clr, rd_en, wr_en}), 0);
      @(negedge clk);
      chk("k0_idle", 32'({busy, done}), 0);
      repeat (2) @(negedge clk);

      // starts during FEED and DONE are ignored
      ndone = 0;
      launch(2, 16'h0100, 16'h0200, 16'h0300);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) ndone++;
         if (c == 4) launch(7, 16'h0AAA, 16'h0BBB, 16'h0CCC);
         if (c == 17) begin
            chk("ign_done_at17", 32'(done), 1);
            launch(7, 16'h0AAA, 16'h0BBB, 16'h0CCC);
         end
         if (c == 18) chk("ign_idle_at18", 32'(busy), 0);
      end
      chk("ign_done_count", 32'(ndone), 1);
      launch(1, 16'h0500, 16'h0600, 16'h0700);
      @(negedge clk);
      start = 1'b0;
      chk("ign_restart_clr", 32'(array_clr), 1);
      repeat (20) @(negedge clk);

      // address wrap
      launch(4, 16'hFFFE, 16'h0000, 16'hFFFD);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 2) chk("wrap_a0", 32'(a_addr), 32'h0000_FFFE);
         if (c == 3) chk("wrap_a1", 32'(a_addr), 32'h0000_FFFF);
         if (c == 4) chk("wrap_a2", 32'(a_addr), 32'h0000_0000);
         if (c == 5) chk("wrap_a3", 32'(a_addr), 32'h0000_0001);
      end

      // reset during WRITE row 2, then a full run
      launch(1, 16'h0030, 16'h0050, 16'h0080);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("abort_row2", 32'(row_sel), 2);
      chk("abort_wr_addr", 32'(wr_addr), 32'h82);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_zero", {16'(a_addr | b_addr | wr_addr), 8'(lane_valid), 2'(row_sel),
          busy, done, array_clr, rd_en, wr_en, 1'b0}, 0);
      chk("abort_perf", perf_cycles, 0);
      rst = 1'b0;
      @(negedge clk);
      launch(3, 16'h0010, 16'h0020, 16'h0040);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 18) chk("post_done", 32'(done), 1);
         if (c == 20) chk("post_perf", perf_cycles, perf_exp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
